// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared types and constants for the RV32 memory-bus arbiter.
//                Provides the arbiter state encoding, the master identifiers
//                and a few helpers used when resolving ties.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32_pkg;

  // Arbiter FSM: either nobody owns the bus or one master does.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Bus masters sharing the external memory bus.
  typedef enum logic {
    MASTER_I = 1'b0,
    MASTER_D = 1'b1
  } arb_master_e;

  // All byte lanes enabled: used for every instruction fetch.
  localparam logic [3:0] BusBeAll = 4'hF;

  // The master that did not win last time; round-robin tie breaker.
  function automatic arb_master_e other_master(input arb_master_e m);
    return (m == MASTER_I) ? MASTER_D : MASTER_I;
  endfunction

  // Grant state that corresponds to a given master.
  function automatic arb_state_e grant_state(input arb_master_e m);
    return (m == MASTER_I) ? GRANT_I : GRANT_D;
  endfunction

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_mod_bus_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mod_bus_watchdog
//  Description : Counts the cycles a granted bus transaction has been waiting
//                for a response and flags expiry when the limit is reached.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock, all state on rising edge
//    reset_n  in   asynchronous active-low reset
//    start    in   a grant begins at the next edge: clear the counter
//    done     in   bus answered (ack or err) this cycle
//    enable   in   a transaction currently owns the bus
//    expired  out  transaction has waited TIMEOUT_CYCLES cycles, abort now
//
//  TIMEOUT_CYCLES = 0 disables the watchdog (expired is held low).
// ============================================================================
module rv32_mod_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic done,
  input  logic enable,
  output logic expired
);

  localparam bit          WD_ON     = (TIMEOUT_CYCLES != 0);
  // Guard the width so a disabled watchdog still elaborates a legal vector.
  localparam int unsigned CNT_W     = WD_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LIMIT_INT = WD_ON ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_INT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The counter reads 0 in the first granted cycle, so the abort fires in
  // the TIMEOUT_CYCLES-th cycle of the grant. A response in the same cycle
  // as the limit takes priority over the abort.
  assign expired = WD_ON && enable && !done && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (enable && !done && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : rv32_mod_bus_watchdog
`default_nettype wire

// File: rtl/rv32_mod_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mod_bus_arbiter
//  Description : Shares one external req/ack/err memory bus between the
//                instruction-fetch port and the load/store port. Round-robin
//                arbitration, grant held until the bus answers, response
//                routed combinationally to the owner, watchdog abort for
//                transactions the bus never answers.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, reset_n                      clock / async active-low reset
//    instr_req, instr_addr             fetch request (level) and address
//    instr_ack, instr_err, instr_data_o  fetch response (one-cycle pulses)
//    data_req, data_we, data_be,       load/store request and attributes
//    data_addr, data_data_i
//    data_ack, data_err, data_data_o   load/store response
//    mem_req, mem_we, mem_be,          external bus request side
//    mem_addr, mem_data_o
//    mem_ack, mem_err, mem_data_i      external bus response side
// ============================================================================
module rv32_mod_bus_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction fetch port
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  // load/store port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,
  // external memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data_i
);

  arb_state_e  state_q;
  arb_state_e  state_d;
  arb_master_e last_grant_q;
  arb_master_e last_grant_d;

  logic w_wd_start;
  logic w_wd_enable;
  logic w_wd_done;
  logic w_wd_expired;
  logic w_resp_ack;
  logic w_resp_err;
  logic w_finish;

  // --------------------------------------------------------------------------
  // Watchdog: cleared when a grant is about to be issued, counts while the
  // owner waits for the bus.
  // --------------------------------------------------------------------------
  assign w_wd_start  = (state_q == IDLE) && (instr_req || data_req);
  assign w_wd_enable = (state_q != IDLE);
  assign w_wd_done   = mem_ack || mem_err;

  rv32_mod_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_wd_start),
    .done    (w_wd_done),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  // Response decode for whichever master owns the bus. An error from the
  // bus or the watchdog always wins over a simultaneous ack.
  assign w_resp_ack = mem_ack && !mem_err;
  assign w_resp_err = mem_err || w_wd_expired;
  assign w_finish   = mem_ack || mem_err || w_wd_expired;

  // --------------------------------------------------------------------------
  // Next state and outputs. Every output defaults to 0 so that IDLE drives a
  // quiet bus and a non-owning master never sees a response; a late
  // ack/err arriving in IDLE therefore has no effect.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = 32'h0;
    mem_data_o   = 32'h0;

    instr_ack    = 1'b0;
    instr_err    = 1'b0;
    instr_data_o = 32'h0;
    data_ack     = 1'b0;
    data_err     = 1'b0;
    data_data_o  = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (instr_req && data_req) begin
          state_d = grant_state(other_master(last_grant_q));
        end else if (instr_req) begin
          state_d = GRANT_I;
        end else if (data_req) begin
          state_d = GRANT_D;
        end
      end

      GRANT_I: begin
        // Fetches are always full-word reads.
        mem_req      = 1'b1;
        mem_be       = BusBeAll;
        mem_addr     = instr_addr;
        instr_ack    = w_resp_ack;
        instr_err    = w_resp_err;
        instr_data_o = w_resp_ack ? mem_data_i : 32'h0;
        if (w_finish) begin
          state_d      = IDLE;
          last_grant_d = MASTER_I;
        end
      end

      GRANT_D: begin
        mem_req     = 1'b1;
        mem_we      = data_we;
        mem_be      = data_be;
        mem_addr    = data_addr;
        mem_data_o  = data_data_i;
        data_ack    = w_resp_ack;
        data_err    = w_resp_err;
        data_data_o = w_resp_ack ? mem_data_i : 32'h0;
        if (w_finish) begin
          state_d      = IDLE;
          last_grant_d = MASTER_D;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to DATA so the fetch port wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= MASTER_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule : rv32_mod_bus_arbiter
`default_nettype wire

// File: tb/tb_rv32_mod_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_mod_bus_arbiter
//  Description : Directed self-checking bench for rv32_mod_bus_arbiter with a
//                reference model of the arbitration rules and a small bus
//                responder with programmable wait states.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32_mod_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'h0;
  logic        instr_ack, instr_err;
  logic [31:0] instr_data_o;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_data_i = 32'h0;
  logic        data_ack, data_err;
  logic [31:0] data_data_o;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_data_o;
  logic        mem_ack, mem_err;
  logic [31:0] mem_data_i;

  // Bus responder: mode 0 ack, 1 err, 2 ack+err, 3 never answers.
  // It answers bus_wait+1 cycles after first seeing mem_req.
  int          bus_mode = 0;
  int          bus_wait = 0;
  int          bus_cnt  = 0;
  logic        bus_ack_r = 1'b0;
  logic        bus_err_r = 1'b0;
  logic        inj_ack   = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  assign mem_ack    = bus_ack_r | inj_ack;
  assign mem_err    = bus_err_r;
  assign mem_data_i = bus_rdata;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Model state: owner 0 = none, 1 = fetch, 2 = load/store.
  int m_owner = 0;
  int m_last  = 2;
  int m_age   = 0;

  rv32_mod_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_err(instr_err), .instr_data_o(instr_data_o),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_data_i(data_data_i),
    .data_ack(data_ack), .data_err(data_err), .data_data_o(data_data_o),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bus_ack_r = 1'b0;
    bus_err_r = 1'b0;
    if (mem_req && bus_mode != 3) begin
      if (bus_cnt == bus_wait + 1) begin
        bus_ack_r = (bus_mode == 0 || bus_mode == 2);
        bus_err_r = (bus_mode == 1 || bus_mode == 2);
        bus_cnt   = 0;
      end else begin
        bus_cnt = bus_cnt + 1;
      end
    end else begin
      bus_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs for the current cycle from the arbitration rules, then
  // advance the model to the next cycle.
  task automatic model_step();
    logic [31:0] e_req, e_we, e_be, e_addr, e_wd;
    logic [31:0] e_ia, e_ie, e_id, e_da, e_de, e_dd;
    bit ack, err, tmo;
    e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
    e_ia = 0; e_ie = 0; e_id = 0; e_da = 0; e_de = 0; e_dd = 0;
    if (!reset_n) begin
      m_owner = 0; m_last = 2; m_age = 0;
    end else if (m_owner == 0) begin
      if (instr_req && data_req) m_owner = (m_last == 2) ? 1 : 2;
      else if (instr_req)        m_owner = 1;
      else if (data_req)         m_owner = 2;
      m_age = 0;
    end else begin
      e_req = 1;
      if (m_owner == 1) begin
        e_be = 32'hF; e_addr = instr_addr;
      end else begin
        e_we = 32'(data_we); e_be = 32'(data_be); e_addr = data_addr; e_wd = data_data_i;
      end
      tmo = (T != 0) && (m_age == T - 1) && !mem_ack && !mem_err;
      ack = mem_ack && !mem_err;
      err = mem_err || tmo;
      if (m_owner == 1) begin
        e_ia = 32'(ack); e_ie = 32'(err); e_id = ack ? mem_data_i : 32'h0;
      end else begin
        e_da = 32'(ack); e_de = 32'(err); e_dd = ack ? mem_data_i : 32'h0;
      end
      if (ack || err) begin
        m_last = m_owner; m_owner = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
    chk("mdl_mem_req",  32'(mem_req), e_req);
    chk("mdl_mem_we",   32'(mem_we),  e_we);
    chk("mdl_mem_be",   32'(mem_be),  e_be);
    chk("mdl_mem_addr", mem_addr,     e_addr);
    chk("mdl_mem_wd",   mem_data_o,   e_wd);
    chk("mdl_i_ack",    32'(instr_ack), e_ia);
    chk("mdl_i_err",    32'(instr_err), e_ie);
    chk("mdl_i_data",   instr_data_o,   e_id);
    chk("mdl_d_ack",    32'(data_ack),  e_da);
    chk("mdl_d_err",    32'(data_err),  e_de);
    chk("mdl_d_data",   data_data_o,    e_dd);
  endtask

  // Inputs change at negedge+1, outputs are checked at negedge+3.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
    model_step();
  endtask

  task automatic wait_resp(input int m, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if ((m == 1 && (instr_ack || instr_err)) || (m == 2 && (data_ack || data_err))) begin
        at = cyc;
        break;
      end
      nxt(); settle();
    end
    if (at < 0) chk("wait_resp_bound", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int g, at, n;
    int ord [8];
    int acyc [8];
    for (int k = 0; k < 8; k++) begin ord[k] = 0; acyc[k] = 0; end

    // ---- reset with both masters requesting ----
    instr_addr = 32'h40; data_addr = 32'h80; bus_rdata = 32'h11111111;
    instr_req = 1'b1; data_req = 1'b1;
    nxt(); settle();
    chk("rst_mem_req",  32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_ack",    32'(instr_ack), 32'd0);
    chk("rst_d_err",    32'(data_err), 32'd0);
    nxt(); reset_n = 1'b1; settle();
    nxt(); settle();
    chk("rel_mem_req",  32'(mem_req), 32'd1);
    chk("rel_mem_addr", mem_addr, 32'h40);
    wait_resp(1, at);
    nxt(); instr_req = 1'b0; settle();
    wait_resp(2, at);
    nxt(); data_req = 1'b0; settle();

    // ---- single fetch, two wait states ----
    nxt(); instr_addr = 32'h100; bus_wait = 2; bus_rdata = 32'hDEADBEEF; instr_req = 1'b1; settle();
    nxt(); settle(); g = cyc;
    chk("sf_grant", 32'(mem_req), 32'd1);
    chk("sf_addr",  mem_addr, 32'h100);
    chk("sf_be",    32'(mem_be), 32'hF);
    wait_resp(1, at);
    chk("sf_latency", 32'(at - g), 32'd3);
    chk("sf_ack",     32'(instr_ack), 32'd1);
    chk("sf_err",     32'(instr_err), 32'd0);
    chk("sf_rdata",   instr_data_o, 32'hDEADBEEF);
    chk("sf_d_ack",   32'(data_ack), 32'd0);
    nxt(); instr_req = 1'b0; settle();

    // ---- store ----
    nxt(); data_we = 1'b1; data_be = 4'b0011; data_addr = 32'h2000; data_data_i = 32'h1234;
    bus_wait = 0; data_req = 1'b1; settle();
    nxt(); settle();
    chk("st_we",    32'(mem_we), 32'd1);
    chk("st_be",    32'(mem_be), 32'h3);
    chk("st_addr",  mem_addr, 32'h2000);
    chk("st_wdata", mem_data_o, 32'h1234);
    nxt(); settle();
    chk("st_ack", 32'(data_ack), 32'd1);
    nxt(); data_req = 1'b0; settle();
    chk("st_ack_once", 32'(data_ack), 32'd0);

    // ---- contention, zero-wait bus ----
    nxt(); data_we = 1'b0; data_be = 4'hF; instr_addr = 32'h300; data_addr = 32'h400;
    bus_rdata = 32'hCAFE0000; instr_req = 1'b1; data_req = 1'b1; settle();
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      nxt(); settle();
      if (instr_ack) begin ord[n] = 1; acyc[n] = cyc; n = n + 1; end
      else if (data_ack) begin ord[n] = 2; acyc[n] = cyc; n = n + 1; end
    end
    nxt(); instr_req = 1'b0; data_req = 1'b0; settle();
    chk("cont_count", 32'(n), 32'd8);
    for (int k = 0; k < 8; k++) chk("cont_order", 32'(ord[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    for (int k = 1; k < 8; k++) chk("cont_spacing", 32'(acyc[k] - acyc[k-1]), 32'd3);

    // ---- timeout with a silent bus, then a late ack ----
    nxt(); bus_mode = 3; data_addr = 32'h500; data_req = 1'b1; settle();
    nxt(); settle(); chk("to_grant", 32'(mem_req), 32'd1);
    nxt(); settle(); chk("to_noerr1", 32'(data_err), 32'd0);
    nxt(); settle(); chk("to_noerr2", 32'(data_err), 32'd0);
    nxt(); settle();
    chk("to_err",      32'(data_err), 32'd1);
    chk("to_req_held", 32'(mem_req), 32'd1);
    nxt(); data_req = 1'b0; settle(); chk("to_req_drop", 32'(mem_req), 32'd0);
    nxt(); settle();
    nxt(); inj_ack = 1'b1; settle();
    chk("to_late_dack", 32'(data_ack), 32'd0);
    chk("to_late_iack", 32'(instr_ack), 32'd0);
    nxt(); inj_ack = 1'b0; settle();

    // ---- bus error on a load ----
    nxt(); bus_mode = 1; data_addr = 32'h540; data_req = 1'b1; settle();
    nxt(); settle();
    nxt(); settle();
    chk("de_err", 32'(data_err), 32'd1);
    chk("de_ack", 32'(data_ack), 32'd0);
    nxt(); data_req = 1'b0; settle();

    // ---- ack and err together on a fetch ----
    nxt(); bus_mode = 2; instr_addr = 32'h600; instr_req = 1'b1; settle();
    nxt(); settle(); chk("ep_addr", mem_addr, 32'h600);
    nxt(); settle();
    chk("ep_err",   32'(instr_err), 32'd1);
    chk("ep_ack",   32'(instr_ack), 32'd0);
    chk("ep_d_err", 32'(data_err), 32'd0);
    nxt(); instr_req = 1'b0; settle();

    // ---- reset mid-transaction, then tie goes to fetch again ----
    nxt(); bus_mode = 3; instr_addr = 32'h700; instr_req = 1'b1; settle();
    nxt(); settle(); chk("rm_grant", 32'(mem_req), 32'd1);
    nxt(); reset_n = 1'b0; settle();
    chk("rm_mem_req",  32'(mem_req), 32'd0);
    chk("rm_mem_addr", mem_addr, 32'd0);
    chk("rm_i_err",    32'(instr_err), 32'd0);
    nxt(); data_addr = 32'h800; data_req = 1'b1; settle();
    nxt(); reset_n = 1'b1; bus_mode = 0; settle();
    nxt(); settle();
    chk("rr_tie_addr", mem_addr, 32'h700);
    wait_resp(1, at);
    nxt(); instr_req = 1'b0; settle();
    wait_resp(2, at);
    nxt(); data_req = 1'b0; settle();
    nxt(); settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rv32_mod_bus_arbiter
`default_nettype wire
